// File: rtl/mem_dump_reader_if.sv
// Memory read port and byte-stream signals shared by the dump reader and its
// memory/UART neighbours; master is the reader side.
interface mem_dump_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] i_mem_data;
    logic                  i_tx_ready;
    logic [DATA_WIDTH-1:0] o_mem_address;
    logic                  o_mem_read;
    logic [1:0]            o_mem_size;
    logic                  o_mem_signed;
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;

    modport master (
        input  i_mem_data, i_tx_ready,
        output o_mem_address, o_mem_read, o_mem_size, o_mem_signed, o_tx_data, o_tx_valid
    );

    modport slave (
        output i_mem_data, i_tx_ready,
        input  o_mem_address, o_mem_read, o_mem_size, o_mem_signed, o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/mem_dump_reader.sv
// Walks data memory from address 0 and streams each word MSB-first as bytes
// to the debug UART transmitter.
//
// state   | meaning
// IDLE    | waiting for i_start
// ADDR    | word address driven, read strobe high
// CAPTURE | read held, memory data loaded into the shift register
// SEND    | presenting bytes on the tx stream, stalls on !i_tx_ready
// DONE    | one-cycle completion pulse
module mem_dump_reader #(
    parameter int         DATA_WIDTH = 32,
    parameter int         NUM_WORDS  = 32,
    parameter logic [1:0] SIZE_WORD  = 2'b11
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    mem_dump_reader_if.master         bus,
    output logic                      o_busy,
    output logic                      o_done
);
    localparam int IDX_W = $clog2(NUM_WORDS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      word_idx_q, word_idx_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_ADDR;
                    word_idx_d = '0;
                end
            end
            S_ADDR: state_d = S_CAPTURE;
            S_CAPTURE: begin
                shift_d    = bus.i_mem_data;
                byte_cnt_d = '0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                // Nothing advances until the sink takes the current byte.
                if (bus.i_tx_ready) begin
                    shift_d = shift_q << 8;
                    if (byte_cnt_q == 2'd3) begin
                        if (word_idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            word_idx_d = word_idx_q + 1'b1;
                            state_d    = S_ADDR;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                word_idx_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_mem_address = DATA_WIDTH'(word_idx_q) << 2;
        bus.o_mem_size    = SIZE_WORD;
        bus.o_mem_signed  = 1'b0;
        bus.o_mem_read    = (state_q == S_ADDR) || (state_q == S_CAPTURE);
        bus.o_tx_valid    = (state_q == S_SEND);
        bus.o_tx_data     = (state_q == S_SEND) ? shift_q[DATA_WIDTH-1 -: 8] : 8'h00;
        o_busy            = (state_q != S_IDLE);
        o_done            = (state_q == S_DONE);
    end
endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: a 4-word and a 1-word instance, each checked every
// cycle against a timeline model, plus directed scenarios with literal results.
module tb_mem_dump_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, start4, busy4, done4;
    logic rst1, start1, busy1, done1;
    logic [31:0] mem4 [4];
    logic [31:0] mem1 [1];

    mem_dump_reader_if #(.DATA_WIDTH(32)) bus4 ();
    mem_dump_reader_if #(.DATA_WIDTH(32)) bus1 ();

    assign bus4.i_mem_data = mem4[bus4.o_mem_address[3:2]];
    assign bus1.i_mem_data = (bus1.o_mem_address == 32'd0) ? mem1[0] : 32'hDEAD_BEEF;

    mem_dump_reader #(.DATA_WIDTH(32), .NUM_WORDS(4), .SIZE_WORD(2'b11)) dut4 (
        .i_clock(clk), .i_reset(rst4), .i_start(start4), .bus(bus4),
        .o_busy(busy4), .o_done(done4)
    );
    mem_dump_reader #(.DATA_WIDTH(32), .NUM_WORDS(1), .SIZE_WORD(2'b11)) dut1 (
        .i_clock(clk), .i_reset(rst1), .i_start(start1), .bus(bus1),
        .o_busy(busy1), .o_done(done1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Timeline model: after an accepted start (or a finished non-last word) the
    // read strobe is high for two cycles, then four bytes are offered until taken.
    typedef struct {
        bit active;
        int rd_left;
        int word_k;
        int bytes_left;
        bit done_due;
    } mdl_t;

    mdl_t m4 = '{default: 0};
    mdl_t m1 = '{default: 0};

    function automatic mdl_t step(input mdl_t m, input logic r, input logic s,
                                  input logic rdy, input int n);
        mdl_t x = m;
        if (r) begin
            x = '{default: 0};
        end else if (!m.active) begin
            if (s) begin
                x.active = 1'b1; x.rd_left = 2; x.word_k = 0; x.bytes_left = 4;
            end
        end else if (m.done_due) begin
            x.done_due = 1'b0; x.active = 1'b0;
        end else if (m.rd_left > 0) begin
            x.rd_left = m.rd_left - 1;
        end else if (rdy) begin
            x.bytes_left = m.bytes_left - 1;
            if (x.bytes_left == 0) begin
                if (m.word_k == n - 1) x.done_due = 1'b1;
                else begin
                    x.word_k = m.word_k + 1; x.rd_left = 2; x.bytes_left = 4;
                end
            end
        end
        return x;
    endfunction

    task automatic check_outputs(input string nm, input mdl_t m, input logic [31:0] word,
                                 input logic [31:0] addr, input logic rd, input logic [1:0] sz,
                                 input logic sg, input logic [7:0] d, input logic v,
                                 input logic b, input logic dn);
        logic exp_v;
        logic [7:0] exp_d;
        exp_v = m.active && (m.rd_left == 0) && (m.bytes_left > 0);
        chk({nm, "_read"},   32'(rd), 32'(m.rd_left > 0));
        chk({nm, "_valid"},  32'(v),  32'(exp_v));
        chk({nm, "_busy"},   32'(b),  32'(m.active));
        chk({nm, "_done"},   32'(dn), 32'(m.done_due));
        chk({nm, "_size"},   32'(sz), 32'd3);
        chk({nm, "_signed"}, 32'(sg), 32'd0);
        if (m.rd_left > 0) chk({nm, "_addr"}, addr, 32'(4 * m.word_k));
        if (exp_v) begin
            exp_d = 8'(word >> (8 * (m.bytes_left - 1)));
            chk({nm, "_byte"}, 32'(d), 32'(exp_d));
        end
    endtask

    logic [7:0] log4_b[$];
    int         log4_a[$];
    int         done4_cnt = 0;
    int         done4_cyc = 0;
    logic       prev_rd4 = 1'b0;
    logic [7:0] log1_b[$];
    int         rd1_cyc[$];
    int         done1_cnt = 0;

    always @(negedge clk) begin
        check_outputs("d4", m4, mem4[m4.word_k[1:0]], bus4.o_mem_address, bus4.o_mem_read,
                      bus4.o_mem_size, bus4.o_mem_signed, bus4.o_tx_data, bus4.o_tx_valid,
                      busy4, done4);
        if (bus4.o_tx_valid && bus4.i_tx_ready) log4_b.push_back(bus4.o_tx_data);
        if (bus4.o_mem_read && !prev_rd4) log4_a.push_back(int'(bus4.o_mem_address));
        prev_rd4 = bus4.o_mem_read;
        if (done4) begin done4_cnt++; done4_cyc = cyc; end
        m4 = step(m4, rst4, start4, bus4.i_tx_ready, 4);
    end

    always @(negedge clk) begin
        check_outputs("d1", m1, mem1[0], bus1.o_mem_address, bus1.o_mem_read,
                      bus1.o_mem_size, bus1.o_mem_signed, bus1.o_tx_data, bus1.o_tx_valid,
                      busy1, done1);
        if (bus1.o_tx_valid && bus1.i_tx_ready) log1_b.push_back(bus1.o_tx_data);
        if (bus1.o_mem_read) rd1_cyc.push_back(cyc);
        if (done1) done1_cnt++;
        m1 = step(m1, rst1, start1, bus1.i_tx_ready, 1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one dump on the 4-word instance; optionally stalls the sink while
    // byte number stall_at is presented. Returns cycles from start to done.
    task automatic dump4(input int stall_at, input int stall_len, output int delta);
        int n, d0, i;
        bit stalled;
        d0 = done4_cnt; stalled = 0; i = 0;
        log4_b.delete(); log4_a.delete();
        start4 = 1'b1; n = cyc; tick; start4 = 1'b0;
        while (done4_cnt == d0 && i < 300) begin
            if (!stalled && stall_len > 0 && log4_b.size() == stall_at && bus4.o_tx_valid) begin
                bus4.i_tx_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick;
                    chk("stall_hold_data", 32'(bus4.o_tx_data), 32'h0000_00C0);
                    chk("stall_hold_valid", 32'(bus4.o_tx_valid), 32'd1);
                end
                bus4.i_tx_ready = 1'b1;
                stalled = 1;
            end
            tick; i++;
        end
        chk("dump4_finished", 32'(done4_cnt != d0), 32'd1);
        delta = done4_cyc - n;
    endtask

    task automatic check_stream4(input string nm);
        logic [31:0] w;
        chk({nm, "_nbytes"}, 32'(log4_b.size()), 32'd16);
        chk({nm, "_naddr"}, 32'(log4_a.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            w = 32'hA0B0_C0D0 + 32'(k);
            if (log4_a.size() > k) chk({nm, "_addr_seq"}, 32'(log4_a[k]), 32'(4 * k));
            for (int j = 0; j < 4; j++)
                if (log4_b.size() > 4 * k + j)
                    chk({nm, "_stream"}, 32'(log4_b[4 * k + j]), 32'(w[31 - 8 * j -: 8]));
        end
    endtask

    initial begin
        int delta, n, d0, i;
        rst4 = 1'b1; rst1 = 1'b1; start4 = 1'b1; start1 = 1'b1;
        bus4.i_tx_ready = 1'b0; bus1.i_tx_ready = 1'b0;
        for (int k = 0; k < 4; k++) mem4[k] = 32'h0;
        mem1[0] = 32'h0;

        // Reset with start held high
        repeat (2) tick;
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_valid", 32'(bus4.o_tx_valid), 32'd0);
        chk("rst_data", 32'(bus4.o_tx_data), 32'd0);
        chk("rst_read", 32'(bus4.o_mem_read), 32'd0);
        chk("rst_addr", bus4.o_mem_address, 32'd0);
        chk("rst_size", 32'(bus4.o_mem_size), 32'd3);
        chk("rst_signed", 32'(bus4.o_mem_signed), 32'd0);
        rst4 = 1'b0; rst1 = 1'b0; start4 = 1'b0; start1 = 1'b0;
        repeat (10) tick;
        chk("no_start_after_reset", 32'(busy4), 32'd0);
        chk("no_start_after_reset_1", 32'(busy1), 32'd0);

        // Full-rate dump
        for (int k = 0; k < 4; k++) mem4[k] = 32'hA0B0_C0D0 + 32'(k);
        bus4.i_tx_ready = 1'b1;
        dump4(-1, 0, delta);
        chk("full_rate_done_latency", 32'(delta), 32'd25);
        check_stream4("full");
        repeat (3) tick;

        // Backpressure on byte 2
        dump4(2, 5, delta);
        chk("backpressure_done_latency", 32'(delta), 32'd30);
        check_stream4("bp");
        repeat (3) tick;

        // Start pulses during SEND and DONE are ignored
        d0 = done4_cnt;
        log4_b.delete(); log4_a.delete();
        start4 = 1'b1; n = cyc; tick; start4 = 1'b0;
        while (cyc < n + 4) tick;
        start4 = 1'b1; tick; start4 = 1'b0;
        while (cyc < n + 25) tick;
        start4 = 1'b1; tick; start4 = 1'b0;
        repeat (10) tick;
        chk("busy_start_bytes", 32'(log4_b.size()), 32'd16);
        chk("busy_start_done_count", 32'(done4_cnt - d0), 32'd1);
        chk("busy_start_idle", 32'(busy4), 32'd0);
        dump4(-1, 0, delta);
        chk("restart_latency", 32'(delta), 32'd25);
        check_stream4("restart");
        repeat (3) tick;

        // Reset after the 6th byte
        d0 = done4_cnt; i = 0;
        log4_b.delete(); log4_a.delete();
        start4 = 1'b1; tick; start4 = 1'b0;
        while (log4_b.size() < 6 && i < 100) begin tick; i++; end
        chk("mid_reset_reached", 32'(log4_b.size()), 32'd6);
        rst4 = 1'b1; tick; rst4 = 1'b0;
        chk("mid_reset_valid", 32'(bus4.o_tx_valid), 32'd0);
        chk("mid_reset_busy", 32'(busy4), 32'd0);
        repeat (30) tick;
        chk("mid_reset_no_done", 32'(done4_cnt - d0), 32'd0);
        dump4(-1, 0, delta);
        chk("post_reset_latency", 32'(delta), 32'd25);
        check_stream4("post_reset");

        // Single-word instance
        mem1[0] = 32'hFFFF_FFFF;
        bus1.i_tx_ready = 1'b1;
        log1_b.delete(); rd1_cyc.delete(); d0 = done1_cnt; i = 0;
        start1 = 1'b1; n = cyc; tick; start1 = 1'b0;
        while (done1_cnt == d0 && i < 50) begin tick; i++; end
        repeat (3) tick;
        chk("one_word_done", 32'(done1_cnt - d0), 32'd1);
        chk("one_word_nbytes", 32'(log1_b.size()), 32'd4);
        foreach (log1_b[j]) chk("one_word_byte", 32'(log1_b[j]), 32'h0000_00FF);
        chk("one_word_nreads", 32'(rd1_cyc.size()), 32'd2);
        if (rd1_cyc.size() == 2) begin
            chk("one_word_read0", 32'(rd1_cyc[0]), 32'(n + 1));
            chk("one_word_read1", 32'(rd1_cyc[1]), 32'(n + 2));
        end
        chk("one_word_signed", 32'(bus1.o_mem_signed), 32'd0);

        // Randomised traffic on both instances
        for (int it = 0; it < 4000; it++) begin
            bus4.i_tx_ready = ($urandom_range(0, 99) < 70);
            bus1.i_tx_ready = ($urandom_range(0, 99) < 60);
            rst4 = ($urandom_range(0, 299) == 0);
            rst1 = ($urandom_range(0, 299) == 0);
            start4 = 1'b0; start1 = 1'b0;
            if ($urandom_range(0, 15) == 0) begin
                if (!m4.active) for (int k = 0; k < 4; k++) mem4[k] = $urandom;
                start4 = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) begin
                if (!m1.active) mem1[0] = $urandom;
                start1 = 1'b1;
            end
            tick;
        end
        rst4 = 1'b0; rst1 = 1'b0; start4 = 1'b0; start1 = 1'b0;
        bus4.i_tx_ready = 1'b1; bus1.i_tx_ready = 1'b1;
        repeat (40) tick;
        chk("final_idle4", 32'(busy4), 32'd0);
        chk("final_idle1", 32'(busy1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
